pc_gen: RTL and testbench

Program-counter generator at the head of PRE_IF. It owns the fetch PC register, consumes the 3-bit next-PC select and candidate addresses produced upstream, and presents PC to the instruction-fetch side with a valid/ready handshake. Redirects that arrive while fetch is stalled are buffered so they are never lost, and fetches issued before a pending redirect is applied are flagged stale.

---
 rtl/pc_gen_pkg.sv | 36 +++
 rtl/pc_gen_if.sv | 25 ++
 rtl/pc_gen_redirect_buffer.sv | 51 +++++
 rtl/pc_gen.sv | 79 +++++++
 tb/tb_pc_gen.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/pc_gen_pkg.sv
// Shared next-PC select encodings and redirect ranking used by pc_gen and its select generator.
// Pure definitions: no timing, no flow control.
package pc_gen_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    localparam logic [2:0] PCSel_PC4     = 3'd0;
    localparam logic [2:0] PCSel_Target  = 3'd1;
    localparam logic [2:0] PCSel_Correct = 3'd2;
    localparam logic [2:0] PCSel_EPC     = 3'd3;
    localparam logic [2:0] PCSel_MEMPC   = 3'd4;
    localparam logic [2:0] PCSel_Except  = 3'd5;

    typedef logic [1:0] redirect_rank_t;

    localparam redirect_rank_t RANK_NONE    = 2'd0;
    localparam redirect_rank_t RANK_CORRECT = 2'd1;
    localparam redirect_rank_t RANK_FLUSH   = 2'd2;

    function automatic logic is_redirect(input logic [2:0] sel);
        return (sel == PCSel_Correct) || (sel == PCSel_EPC) ||
               (sel == PCSel_MEMPC)   || (sel == PCSel_Except);
    endfunction

    // Branch repair ranks below eret/refetch/exception, which all flush the pipe.
    function automatic redirect_rank_t redirect_rank(input logic [2:0] sel);
        redirect_rank_t r;
        r = RANK_NONE;
        if (sel == PCSel_Correct)
            r = RANK_CORRECT;
        else if (is_redirect(sel))
            r = RANK_FLUSH;
        return r;
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-request bundle between pc_gen (master) and the select logic / fetch side (slave).
// Wires only; PC_Valid/IF_Ready is the handshake.
interface pc_gen_if;
    logic [2:0]  PCSel;
    logic [31:0] BPU_Target;
    logic [31:0] EXE_Correct_PC;
    logic [31:0] CP0_EPC;
    logic [31:0] MEM_PC;
    logic [31:0] Except_PC;
    logic        IF_Ready;
    logic        PC_Valid;
    logic [31:0] PC;
    logic        Fetch_Stale;
    logic        Redirect_Pending;

    modport master (
        input  PCSel, BPU_Target, EXE_Correct_PC, CP0_EPC, MEM_PC, Except_PC, IF_Ready,
        output PC_Valid, PC, Fetch_Stale, Redirect_Pending
    );

    modport slave (
        output PCSel, BPU_Target, EXE_Correct_PC, CP0_EPC, MEM_PC, Except_PC, IF_Ready,
        input  PC_Valid, PC, Fetch_Stale, Redirect_Pending
    );
endinterface

// File: rtl/pc_gen_redirect_buffer.sv
// Single-entry redirect holder; a load only replaces a held entry of lower or equal rank.
// 1-cycle load latency; apply (fetch handshake) clears it and wins over a same-cycle load.
module redirect_buffer
    import pc_gen_pkg::*;
(
    input  logic           clk,
    input  logic           resetn,
    input  logic           load_vld,
    input  logic [31:0]    load_target,
    input  redirect_rank_t load_rank,
    input  logic           apply,
    output logic           pend_vld,
    output logic [31:0]    pend_target
);

    logic           vld_q, vld_d;
    logic [31:0]    target_q, target_d;
    redirect_rank_t rank_q, rank_d;
    logic           accept;

    always_comb begin
        vld_d    = vld_q;
        target_d = target_q;
        rank_d   = rank_q;
        accept   = load_vld && (!vld_q || (load_rank >= rank_q));
        if (apply) begin
            vld_d  = 1'b0;
            rank_d = RANK_NONE;
        end else if (accept) begin
            vld_d    = 1'b1;
            target_d = load_target;
            rank_d   = load_rank;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_q    <= 1'b0;
            target_q <= '0;
            rank_q   <= RANK_NONE;
        end else begin
            vld_q    <= vld_d;
            target_q <= target_d;
            rank_q   <= rank_d;
        end
    end

    assign pend_vld    = vld_q;
    assign pend_target = target_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch PC register and next-PC mux; new PC visible 1 cycle after the handshake or redirect edge.
// PC holds while IF_Ready is low; redirects seen during a stall are buffered, never dropped by a stall.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
    input  logic          clk,
    input  logic          resetn,
    pc_gen_if.master      bus
);

    logic [31:0]    pc_q, pc_d;
    logic           pc_valid_q, pc_valid_d;
    logic           hs;
    logic           redirect_now;
    logic [31:0]    redirect_target;
    redirect_rank_t redirect_rnk;
    logic           pend_vld;
    logic [31:0]    pend_target;

    assign hs = pc_valid_q && bus.IF_Ready;

    always_comb begin
        redirect_now    = is_redirect(bus.PCSel);
        redirect_rnk    = redirect_rank(bus.PCSel);
        redirect_target = '0;
        case (bus.PCSel)
            PCSel_Correct: redirect_target = bus.EXE_Correct_PC;
            PCSel_EPC:     redirect_target = bus.CP0_EPC;
            PCSel_MEMPC:   redirect_target = bus.MEM_PC;
            PCSel_Except:  redirect_target = bus.Except_PC;
            default:       redirect_target = '0;
        endcase
    end

    // A live redirect beats a buffered one; the buffer beats the sequential path.
    always_comb begin
        pc_d       = pc_q;
        pc_valid_d = 1'b1;
        if (hs) begin
            if (redirect_now)
                pc_d = redirect_target;
            else if (pend_vld)
                pc_d = pend_target;
            else if (bus.PCSel == PCSel_Target)
                pc_d = bus.BPU_Target;
            else if (bus.PCSel == PCSel_PC4)
                pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q       <= RESET_PC;
            pc_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
        end
    end

    redirect_buffer u_redirect_buffer (
        .clk         (clk),
        .resetn      (resetn),
        .load_vld    (redirect_now && !hs),
        .load_target (redirect_target),
        .load_rank   (redirect_rnk),
        .apply       (hs),
        .pend_vld    (pend_vld),
        .pend_target (pend_target)
    );

    assign bus.PC_Valid         = pc_valid_q;
    assign bus.PC               = pc_q;
    assign bus.Redirect_Pending = pend_vld;
    assign bus.Fetch_Stale      = hs && (redirect_now || pend_vld);

endmodule

// File: tb/tb_pc_gen.sv
// Directed vector bench for pc_gen: table of per-cycle inputs and expected outputs,
// plus a hand-written asynchronous reset-during-stall sequence.
module tb_pc_gen;
    import pc_gen_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    pc_gen_if bus();

    pc_gen dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        logic        rst_n;
        logic [2:0]  sel;
        logic        rdy;
        logic [31:0] addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_stale;
        logic        exp_pend;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic r, input logic [2:0] s, input logic rd,
                                input logic [31:0] a, input logic ev, input logic [31:0] ep,
                                input logic es, input logic epd);
        vec_t v;
        v.rst_n = r; v.sel = s; v.rdy = rd; v.addr = a;
        v.exp_valid = ev; v.exp_pc = ep; v.exp_stale = es; v.exp_pend = epd;
        tbl.push_back(v);
    endfunction

    // Unselected candidates carry junk so a wrong mux leg shows up in PC.
    task automatic drive(input logic [2:0] s, input logic rd, input logic [31:0] a);
        bus.PCSel          = s;
        bus.IF_Ready       = rd;
        bus.BPU_Target     = 32'hDEAD_0001;
        bus.EXE_Correct_PC = 32'hDEAD_0002;
        bus.CP0_EPC        = 32'hDEAD_0003;
        bus.MEM_PC         = 32'hDEAD_0004;
        bus.Except_PC      = 32'hDEAD_0005;
        case (s)
            PCSel_Target:  bus.BPU_Target     = a;
            PCSel_Correct: bus.EXE_Correct_PC = a;
            PCSel_EPC:     bus.CP0_EPC        = a;
            PCSel_MEMPC:   bus.MEM_PC         = a;
            PCSel_Except:  bus.Except_PC      = a;
            default: ;
        endcase
    endtask

    task automatic check_out(input string tag, input logic ev, input logic [31:0] ep,
                             input logic es, input logic epd);
        chk({tag, " valid"}, {31'd0, bus.PC_Valid}, {31'd0, ev});
        chk({tag, " pc"}, bus.PC, ep);
        chk({tag, " stale"}, {31'd0, bus.Fetch_Stale}, {31'd0, es});
        chk({tag, " pending"}, {31'd0, bus.Redirect_Pending}, {31'd0, epd});
    endtask

    initial begin
        drive(PCSel_PC4, 1'b1, 32'h0);
        #1 resetn = 1'b0;

        // reset and sequential fetch
        add(0, PCSel_PC4, 1, 0, 0, 32'hBFC00000, 0, 0);
        add(1, PCSel_PC4, 1, 0, 0, 32'hBFC00000, 0, 0);
        add(1, PCSel_PC4, 1, 0, 1, 32'hBFC00000, 0, 0);
        add(1, PCSel_PC4, 1, 0, 1, 32'hBFC00004, 0, 0);
        add(1, PCSel_PC4, 1, 0, 1, 32'hBFC00008, 0, 0);
        add(1, PCSel_PC4, 1, 0, 1, 32'hBFC0000C, 0, 0);
        // 5-cycle stall with Target selected
        for (int i = 0; i < 5; i++)
            add(1, PCSel_Target, 0, 32'h80001000, 1, 32'hBFC00010, 0, 0);
        add(1, PCSel_Target, 1, 32'h80001000, 1, 32'hBFC00010, 0, 0);
        // redirect during stall
        add(1, PCSel_PC4,     0, 0,            1, 32'h80001000, 0, 0);
        add(1, PCSel_Correct, 0, 32'h80002000, 1, 32'h80001000, 0, 0);
        add(1, PCSel_PC4,     0, 0,            1, 32'h80001000, 0, 1);
        add(1, PCSel_PC4,     1, 0,            1, 32'h80001000, 1, 1);
        add(1, PCSel_PC4,     0, 0,            1, 32'h80002000, 0, 0);
        // Except then lower-ranked Correct: Correct dropped
        add(1, PCSel_Except,  0, 32'hBFC00380, 1, 32'h80002000, 0, 0);
        add(1, PCSel_Correct, 0, 32'h80003000, 1, 32'h80002000, 0, 1);
        add(1, PCSel_PC4,     1, 0,            1, 32'h80002000, 1, 1);
        add(1, PCSel_PC4,     0, 0,            1, 32'hBFC00380, 0, 0);
        // Correct then Except: Except overwrites
        add(1, PCSel_Correct, 0, 32'h80003000, 1, 32'hBFC00380, 0, 0);
        add(1, PCSel_Except,  0, 32'hBFC00380, 1, 32'hBFC00380, 0, 1);
        add(1, PCSel_PC4,     1, 0,            1, 32'hBFC00380, 1, 1);
        add(1, PCSel_PC4,     1, 0,            1, 32'hBFC00380, 0, 0);
        // equal rank: later EPC overwrites MEMPC
        add(1, PCSel_MEMPC,   0, 32'h80005000, 1, 32'hBFC00384, 0, 0);
        add(1, PCSel_EPC,     0, 32'h80006000, 1, 32'hBFC00384, 0, 1);
        add(1, PCSel_PC4,     1, 0,            1, 32'hBFC00384, 1, 1);
        // redirect with hs: applied directly, nothing buffered
        add(1, PCSel_EPC,     1, 32'h80004000, 1, 32'h80006000, 1, 0);
        add(1, PCSel_Target,  1, 32'h80007000, 1, 32'h80004000, 0, 0);
        // PC+4 wrap
        add(1, PCSel_Target,  1, 32'hFFFFFFFC, 1, 32'h80007000, 0, 0);
        add(1, PCSel_PC4,     1, 0,            1, 32'hFFFFFFFC, 0, 0);
        add(1, PCSel_PC4,     1, 0,            1, 32'h00000000, 0, 0);
        // redirect in the reset-release cycle is buffered, RESET_PC fetch stale
        add(0, PCSel_PC4,     1, 0,            0, 32'hBFC00000, 0, 0);
        add(1, PCSel_Correct, 1, 32'h80008000, 0, 32'hBFC00000, 0, 0);
        add(1, PCSel_PC4,     1, 0,            1, 32'hBFC00000, 1, 1);
        add(1, PCSel_PC4,     1, 0,            1, 32'h80008000, 0, 0);

        foreach (tbl[i]) begin
            @(negedge clk);
            resetn = tbl[i].rst_n;
            drive(tbl[i].sel, tbl[i].rdy, tbl[i].addr);
            #1;
            check_out($sformatf("vec%0d", i), tbl[i].exp_valid, tbl[i].exp_pc,
                      tbl[i].exp_stale, tbl[i].exp_pend);
        end

        // reset asserted mid-stall with the buffer occupied
        @(negedge clk);
        drive(PCSel_Correct, 1'b0, 32'h80009000);
        #1 check_out("mid_pre", 1'b1, 32'h80008004, 1'b0, 1'b0);
        @(negedge clk);
        drive(PCSel_PC4, 1'b0, 32'h0);
        #1 check_out("mid_held", 1'b1, 32'h80008004, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        bus.IF_Ready = 1'b1;
        resetn = 1'b0;
        #1 check_out("mid_rst", 1'b0, 32'hBFC00000, 1'b0, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        #1 check_out("mid_rel", 1'b0, 32'hBFC00000, 1'b0, 1'b0);
        @(negedge clk);
        #1 check_out("mid_first", 1'b1, 32'hBFC00000, 1'b0, 1'b0);
        @(negedge clk);
        #1 check_out("mid_next", 1'b1, 32'hBFC00004, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
